// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies a stable lock, releases
// the core reset, and relocks on loss of lock; parks in FAULT after repeated failures.
module pll_lock_supervisor #(
  parameter int PWRUP_CYC        = 1000,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int LOCK_STABLE_CYC  = 50000,
  parameter int MAX_RETRY        = 3,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int MAX_AB = (PWRUP_CYC > LOCK_TIMEOUT_CYC) ? PWRUP_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   w_fail;
  logic                   w_lost;
  logic                   r_pll_rst;
  logic                   r_core_reset;
  logic                   r_ready;
  logic                   r_fault;
  logic [3:0]             r_retry;
  logic [7:0]             r_lost;

  // pll_locked is asynchronous to refclk; only the last stage is ever observed.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fail      = 1'b0;
    w_lost      = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == PWRUP_LAST) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_lock_s)                    w_state_nxt = S_STABLE;
        else if (r_cnt == TIMEOUT_LAST)  w_fail      = 1'b1;
      end
      S_STABLE: begin
        if (!w_lock_s)                   w_fail      = 1'b1;
        else if (r_cnt == STABLE_LAST)   w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_HOLD;
          w_lost      = 1'b1;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_HOLD;
    endcase
    if (w_fail) w_state_nxt = (r_retry == RETRY_MAX) ? S_FAULT : S_HOLD;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_pll_rst    <= 1'b1;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retry      <= '0;
      r_lost       <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_state_nxt != r_state || r_state == S_RUN || r_state == S_FAULT) r_cnt <= '0;
      else                                                                  r_cnt <= r_cnt + CNT_W'(1);

      if (w_fail && r_retry != RETRY_MAX)             r_retry <= r_retry + 4'd1;
      else if (w_state_nxt == S_RUN && r_state != S_RUN) r_retry <= '0;

      if (w_lost && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;

      r_pll_rst    <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_FAULT);
      r_core_reset <= (w_state_nxt != S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  assign pll_rst    = r_pll_rst;
  assign core_reset = r_core_reset;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign retry_cnt  = r_retry;
  assign lost_cnt   = r_lost;

endmodule
